ola_trigger_config: RTL and testbench

Write sequencer for the serial configuration port of ola_trigger. It accepts one parallel register-write request at a time (state select, register select, data word, bit count) over a valid/ready handshake. It serializes the data LSB-first onto ctl_enable/ctl_data while holding ctl_state_which/ctl_state_what stable. It sits between the host/command decoder and ola_trigger, and replaces hand-driven shift sequences.

---
 rtl/ola_trigger_pkg.sv | 22 ++
 rtl/ola_ctl_shifter.sv | 46 ++++
 rtl/ola_trigger_config.sv | 143 ++++++++++++++
 tb/tb_ola_trigger_config.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/ola_trigger_pkg.sv
// Shared widths, register encodings and FSM states for ola_trigger
// and its configuration write sequencer.
package ola_trigger_pkg;

  localparam int STATE_SEL_W = 2;
  localparam int STATE_REG_W = 2;
  localparam int MAX_BITS    = 16;
  localparam int COUNT_W     = 5;

  localparam logic [STATE_REG_W-1:0] WHAT_REG0 = 2'd0;
  localparam logic [STATE_REG_W-1:0] WHAT_REG1 = 2'd1;
  localparam logic [STATE_REG_W-1:0] WHAT_REG2 = 2'd2;
  localparam logic [STATE_REG_W-1:0] WHAT_REG3 = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_COMMIT,
    ST_ERR
  } state_e;

endpackage

// File: rtl/ola_ctl_shifter.sv
// Data shift register and bit down-counter for one serial write.
// cur_bit is the bit to present in the next shift cycle.
module ola_ctl_shifter #(
  parameter int max_bits    = 16,
  parameter int count_width = 5
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   load,
  input  logic                   shift,
  input  logic [max_bits-1:0]    load_data,
  input  logic [count_width-1:0] load_count,
  output logic                   cur_bit,
  output logic                   last
);

  // bit 0 leaves straight from load_data, so only the rest is stored
  logic [max_bits-2:0]    sh_q, sh_d;
  logic [count_width-1:0] cnt_q, cnt_d;

  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (load) begin
      sh_d  = load_data[max_bits-1:1];
      cnt_d = load_count;
    end else if (shift) begin
      sh_d  = sh_q >> 1;
      cnt_d = cnt_q - count_width'(1);
    end
  end

  assign cur_bit = load ? load_data[0] : sh_q[0];
  assign last    = (cnt_q == count_width'(1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ola_trigger_config.sv
// Serial configuration write sequencer for ola_trigger: one request,
// shifted LSB-first on ctl_enable/ctl_data, then a one-cycle commit.
module ola_trigger_config
  import ola_trigger_pkg::*;
#(
  parameter int state_sel_width = STATE_SEL_W,
  parameter int state_reg_width = STATE_REG_W,
  parameter int max_bits        = MAX_BITS,
  parameter int count_width     = COUNT_W
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [state_sel_width-1:0] req_which,
  input  logic [state_reg_width-1:0] req_what,
  input  logic [max_bits-1:0]        req_data,
  input  logic [count_width-1:0]     req_count,
  output logic                       ctl_enable,
  output logic                       ctl_data,
  output logic [state_sel_width-1:0] ctl_state_which,
  output logic [state_reg_width-1:0] ctl_state_what,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  state_e state_q, state_d;
  logic   ready_q, ready_d;
  logic   en_q, en_d;
  logic   dat_q, dat_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;
  logic   err_q, err_d;
  logic [state_sel_width-1:0] which_q, which_d;
  logic [state_reg_width-1:0] what_q, what_d;

  logic load, shift, cur_bit, last;
  logic accept, legal;

  assign accept = req_valid && ready_q;
  assign legal  = (req_count != '0) &&
                  (req_count <= count_width'(max_bits));

  ola_ctl_shifter #(
    .max_bits    (max_bits),
    .count_width (count_width)
  ) u_shifter (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (load),
    .shift      (shift),
    .load_data  (req_data),
    .load_count (req_count),
    .cur_bit    (cur_bit),
    .last       (last)
  );

  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    en_d    = 1'b0;
    dat_d   = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    which_d = which_q;
    what_d  = what_q;
    load    = 1'b0;
    shift   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (accept) begin
          which_d = req_which;
          what_d  = req_what;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          if (legal) begin
            load    = 1'b1;
            en_d    = 1'b1;
            dat_d   = cur_bit;
            state_d = ST_SHIFT;
          end else begin
            err_d   = 1'b1;
            state_d = ST_ERR;
          end
        end
      end
      ST_SHIFT: begin
        if (last) begin
          done_d  = 1'b1;
          state_d = ST_COMMIT;
        end else begin
          shift = 1'b1;
          en_d  = 1'b1;
          dat_d = cur_bit;
        end
      end
      ST_COMMIT, ST_ERR: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      en_q    <= 1'b0;
      dat_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      which_q <= '0;
      what_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      en_q    <= en_d;
      dat_q   <= dat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      which_q <= which_d;
      what_q  <= what_d;
    end
  end

  assign req_ready       = ready_q;
  assign ctl_enable      = en_q;
  assign ctl_data        = dat_q;
  assign ctl_state_which = which_q;
  assign ctl_state_what  = what_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign err             = err_q;

endmodule

// File: tb/tb_ola_trigger_config.sv
// Directed bench for ola_trigger_config: reset, writes, back-to-back,
// illegal counts and reset during a shift.
module tb_ola_trigger_config;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_which = '0;
  logic [1:0]  req_what = '0;
  logic [15:0] req_data = '0;
  logic [4:0]  req_count = '0;
  logic        ctl_enable, ctl_data;
  logic [1:0]  ctl_state_which, ctl_state_what;
  logic        busy, done, err;

  int total = 0;
  int bad   = 0;

  ola_trigger_config dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_which       (req_which),
    .req_what        (req_what),
    .req_data        (req_data),
    .req_count       (req_count),
    .ctl_enable      (ctl_enable),
    .ctl_data        (ctl_data),
    .ctl_state_which (ctl_state_which),
    .ctl_state_what  (ctl_state_what),
    .busy            (busy),
    .done            (done),
    .err             (err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Full write: checks every cycle from shift cycle 1 to ready again.
  task automatic do_write(input logic [1:0] w, input logic [1:0] r,
                          input logic [15:0] d, input int n);
    chk("pre_ready", 32'(req_ready), 1);
    req_valid = 1'b1;
    req_which = w;
    req_what  = r;
    req_data  = d;
    req_count = 5'(n);
    tick;
    req_valid = 1'b0;
    chk("acc_ready", 32'(req_ready), 0);
    chk("acc_busy", 32'(busy), 1);
    for (int k = 1; k <= n; k++) begin
      chk("sh_en", 32'(ctl_enable), 1);
      chk("sh_bit", 32'(ctl_data), 32'(d[k-1]));
      chk("sh_which", 32'(ctl_state_which), 32'(w));
      chk("sh_what", 32'(ctl_state_what), 32'(r));
      chk("sh_done", 32'(done), 0);
      chk("sh_ready", 32'(req_ready), 0);
      if (k < n) tick;
    end
    tick;
    chk("cm_done", 32'(done), 1);
    chk("cm_en", 32'(ctl_enable), 0);
    chk("cm_data", 32'(ctl_data), 0);
    chk("cm_which", 32'(ctl_state_which), 32'(w));
    chk("cm_what", 32'(ctl_state_what), 32'(r));
    chk("cm_busy", 32'(busy), 1);
    tick;
    chk("end_ready", 32'(req_ready), 1);
    chk("end_done", 32'(done), 0);
    chk("end_busy", 32'(busy), 0);
    chk("end_which", 32'(ctl_state_which), 32'(w));
  endtask

  task automatic bad_count(input logic [4:0] c);
    chk("er_pre", 32'(req_ready), 1);
    req_valid = 1'b1;
    req_count = c;
    req_data  = 16'hFFFF;
    tick;
    req_valid = 1'b0;
    chk("er_err", 32'(err), 1);
    chk("er_en", 32'(ctl_enable), 0);
    chk("er_done", 32'(done), 0);
    chk("er_busy", 32'(busy), 1);
    chk("er_ready", 32'(req_ready), 0);
    tick;
    chk("er_err2", 32'(err), 0);
    chk("er_en2", 32'(ctl_enable), 0);
    chk("er_done2", 32'(done), 0);
    chk("er_ready2", 32'(req_ready), 1);
    chk("er_busy2", 32'(busy), 0);
  endtask

  initial begin
    logic exp_en;
    logic [1:0] exp_w;

    // 1: reset
    repeat (3) @(posedge clock);
    #1;
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_en", 32'(ctl_enable), 0);
    chk("rst_data", 32'(ctl_data), 0);
    chk("rst_which", 32'(ctl_state_which), 0);
    chk("rst_what", 32'(ctl_state_what), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("rel_ready0", 32'(req_ready), 0);
    tick;
    chk("rel_ready1", 32'(req_ready), 1);
    chk("rel_busy", 32'(busy), 0);

    // 2 and 3
    do_write(2'd0, 2'd0, 16'h0006, 4);
    do_write(2'd1, 2'd2, 16'h0200, 16);

    // 4: back-to-back with req_valid held
    req_valid = 1'b1;
    req_which = 2'd0;
    req_what  = 2'd0;
    req_data  = 16'h0006;
    req_count = 5'd4;
    tick;
    req_which = 2'd1;
    req_what  = 2'd2;
    req_data  = 16'h0200;
    req_count = 5'd16;
    for (int c = 1; c <= 24; c++) begin
      exp_en = ((c >= 1) && (c <= 4)) || ((c >= 7) && (c <= 22));
      exp_w  = (c <= 6) ? 2'd0 : 2'd1;
      chk("b2b_en", 32'(ctl_enable), 32'(exp_en));
      chk("b2b_which", 32'(ctl_state_which), 32'(exp_w));
      chk("b2b_ready", 32'(req_ready),
          32'((c == 6) || (c == 24)));
      chk("b2b_done", 32'(done), 32'((c == 5) || (c == 23)));
      chk("b2b_data", 32'(ctl_data), 32'((c == 2) || (c == 3) || (c == 16)));
      if (c == 7) req_valid = 1'b0;
      if (c < 24) tick;
    end

    // 5: illegal counts
    bad_count(5'd0);
    bad_count(5'd17);

    // 6: reset during a count-16 write
    req_valid = 1'b1;
    req_which = 2'd3;
    req_what  = 2'd1;
    req_data  = 16'hFFFF;
    req_count = 5'd16;
    tick;
    req_valid = 1'b0;
    tick;
    chk("mid_en", 32'(ctl_enable), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_en", 32'(ctl_enable), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_ready", 32'(req_ready), 0);
    chk("mid_rst_done", 32'(done), 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    tick;
    chk("post_done", 32'(done), 0);
    chk("post_which", 32'(ctl_state_which), 0);
    do_write(2'd0, 2'd0, 16'h0006, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
